// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: active-low segment codes (bit 0 = segment a)
// and the word-decoder state type.
package ssd_pkg;

  localparam logic [0:6] SSD_0 = 7'b0000001;
  localparam logic [0:6] SSD_1 = 7'b1001111;
  localparam logic [0:6] SSD_2 = 7'b0010010;
  localparam logic [0:6] SSD_3 = 7'b0000110;
  localparam logic [0:6] SSD_4 = 7'b1001100;
  localparam logic [0:6] SSD_5 = 7'b0100100;
  localparam logic [0:6] SSD_6 = 7'b0100000;
  localparam logic [0:6] SSD_7 = 7'b0001111;
  localparam logic [0:6] SSD_8 = 7'b0000000;
  localparam logic [0:6] SSD_9 = 7'b0001100;
  localparam logic [0:6] SSD_A = 7'b0001000;
  localparam logic [0:6] SSD_B = 7'b1100000;
  localparam logic [0:6] SSD_C = 7'b0110001;
  localparam logic [0:6] SSD_D = 7'b1000010;
  localparam logic [0:6] SSD_E = 7'b0110000;
  localparam logic [0:6] SSD_F = 7'b0111000;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } ssd_state_t;

endpackage

// File: rtl/ssd_to_hex.sv
// Combinational inverse of the seven-segment encoder: code -> {err, nibble}.
// Unrecognised codes decode to zero with the error bit set.
module ssd_to_hex
  import ssd_pkg::*;
(
  input  logic [0:6] i_code,
  output logic [3:0] o_nibble,
  output logic       o_err
);

  always_comb begin
    o_nibble = 4'h0;
    o_err    = 1'b0;
    case (i_code)
      SSD_0:   o_nibble = 4'h0;
      SSD_1:   o_nibble = 4'h1;
      SSD_2:   o_nibble = 4'h2;
      SSD_3:   o_nibble = 4'h3;
      SSD_4:   o_nibble = 4'h4;
      SSD_5:   o_nibble = 4'h5;
      SSD_6:   o_nibble = 4'h6;
      SSD_7:   o_nibble = 4'h7;
      SSD_8:   o_nibble = 4'h8;
      SSD_9:   o_nibble = 4'h9;
      SSD_A:   o_nibble = 4'hA;
      SSD_B:   o_nibble = 4'hB;
      SSD_C:   o_nibble = 4'hC;
      SSD_D:   o_nibble = 4'hD;
      SSD_E:   o_nibble = 4'hE;
      SSD_F:   o_nibble = 4'hF;
      default: o_err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/ssd_word_decoder.sv
// Assembles a stream of seven-segment digit codes (MSD first) into one word,
// held with an error flag in a single-entry output buffer until taken.
module ssd_word_decoder
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    Clk,
  input  logic                    Clr,
  input  logic                    Flush,
  input  logic [0:6]              SSD_In,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  output logic [4*NUM_DIGITS-1:0] Q,
  output logic                    Q_Err,
  output logic                    Q_Valid,
  input  logic                    Q_Ready
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(NUM_DIGITS - 1);

  ssd_state_t      r_state;
  ssd_state_t      w_nextState;
  logic [CW-1:0]   r_count;
  logic [W-1:0]    r_shift;
  logic [W-1:0]    r_q;
  logic            r_errAcc;
  logic            r_qErr;

  logic [3:0]      w_nibble;
  logic            w_digitErr;
  logic [W-1:0]    w_shiftNext;
  logic            w_inReady;
  logic            w_accept;
  logic            w_take;
  logic            w_lastDigit;

  ssd_to_hex u_decode (
    .i_code   (SSD_In),
    .o_nibble (w_nibble),
    .o_err    (w_digitErr)
  );

  // Shift-left form keeps every register bit in use and also covers NUM_DIGITS=1.
  assign w_shiftNext = (r_shift << 4) | W'(w_nibble);
  assign w_lastDigit = (r_count == LAST_COUNT);
  assign w_take      = (r_state == FULL) && Q_Ready;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // While FULL the buffer frees up only when downstream takes it, so a new
  // digit can enter in that same cycle. Flush overrides every handshake.
  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b1;
    if (r_state == FULL) begin
      w_inReady = Q_Ready;
    end
    w_accept = In_Valid && w_inReady && !Flush;
    if (Flush) begin
      w_nextState = COLLECT;
    end else if (w_accept && w_lastDigit) begin
      w_nextState = FULL;
    end else if (w_take) begin
      w_nextState = COLLECT;
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_count  <= '0;
      r_shift  <= '0;
      r_errAcc <= 1'b0;
      r_q      <= '0;
      r_qErr   <= 1'b0;
    end else if (Flush) begin
      r_count  <= '0;
      r_shift  <= '0;
      r_errAcc <= 1'b0;
    end else if (w_accept) begin
      r_shift <= w_shiftNext;
      if (w_lastDigit) begin
        r_q      <= w_shiftNext;
        r_qErr   <= r_errAcc | w_digitErr;
        r_count  <= '0;
        r_errAcc <= 1'b0;
      end else begin
        r_count  <= r_count + CW'(1);
        r_errAcc <= r_errAcc | w_digitErr;
      end
    end
  end

  assign In_Ready = w_inReady;
  assign Q_Valid  = (r_state == FULL);
  assign Q        = r_q;
  assign Q_Err    = r_qErr;

endmodule

// File: tb/tb_ssd_word_decoder.sv
// Scoreboard bench: stimulus queues expected words, monitors pop them on each
// output handshake. A second instance covers the single-digit build.
module tb_ssd_word_decoder;
  import ssd_pkg::*;

  logic        Clk = 1'b0;
  logic        Clr;
  logic        Flush;
  logic [0:6]  SSD_In;
  logic        In_Valid;
  logic        In_Ready;
  logic [15:0] Q;
  logic        Q_Err;
  logic        Q_Valid;
  logic        Q_Ready;

  logic        c1Flush;
  logic [0:6]  c1SsdIn;
  logic        c1InValid;
  logic        c1InReady;
  logic [3:0]  c1Q;
  logic        c1QErr;
  logic        c1QValid;
  logic        c1QReady;

  int total = 0;
  int bad   = 0;

  logic [16:0] expQ[$];
  logic [4:0]  expQ1[$];

  ssd_word_decoder #(.NUM_DIGITS(4)) dut (
    .Clk      (Clk),
    .Clr      (Clr),
    .Flush    (Flush),
    .SSD_In   (SSD_In),
    .In_Valid (In_Valid),
    .In_Ready (In_Ready),
    .Q        (Q),
    .Q_Err    (Q_Err),
    .Q_Valid  (Q_Valid),
    .Q_Ready  (Q_Ready)
  );

  ssd_word_decoder #(.NUM_DIGITS(1)) dut1 (
    .Clk      (Clk),
    .Clr      (Clr),
    .Flush    (c1Flush),
    .SSD_In   (c1SsdIn),
    .In_Valid (c1InValid),
    .In_Ready (c1InReady),
    .Q        (c1Q),
    .Q_Err    (c1QErr),
    .Q_Valid  (c1QValid),
    .Q_Ready  (c1QReady)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Presents one digit and holds it until accepted, bounded by a cycle budget.
  task automatic applyStimulus(input logic [0:6] code);
    bit done;
    done     = 1'b0;
    SSD_In   = code;
    In_Valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge Clk);
      if (In_Ready) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL accept timeout: In_Ready stayed 0, expected 1");
    end
    tick();
    In_Valid = 1'b0;
  endtask

  // Monitor for the 4-digit instance.
  always @(negedge Clk) begin : mon4
    logic [16:0] e;
    if (!Clr && Q_Valid && Q_Ready) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected word: got %0h expected none", {Q_Err, Q});
      end else begin
        e = expQ.pop_front();
        checkOutput("word", {15'd0, Q_Err, Q}, {15'd0, e});
      end
    end
  end

  // Monitor for the 1-digit instance.
  always @(negedge Clk) begin : mon1
    logic [4:0] e;
    if (!Clr && c1QValid && c1QReady) begin
      if (expQ1.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected word1: got %0h expected none", {c1QErr, c1Q});
      end else begin
        e = expQ1.pop_front();
        checkOutput("word1", {27'd0, c1QErr, c1Q}, {27'd0, e});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, expected test end");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    Clr       = 1'b1;
    Flush     = 1'b0;
    In_Valid  = 1'b0;
    SSD_In    = SSD_0;
    Q_Ready   = 1'b1;
    c1Flush   = 1'b0;
    c1SsdIn   = SSD_0;
    c1InValid = 1'b0;
    c1QReady  = 1'b1;

    #12;
    checkOutput("reset Q", {16'd0, Q}, 32'h0);
    checkOutput("reset Q_Err", {31'd0, Q_Err}, 32'h0);
    checkOutput("reset Q_Valid", {31'd0, Q_Valid}, 32'h0);
    checkOutput("reset In_Ready", {31'd0, In_Ready}, 32'h1);
    #1 Clr = 1'b0;
    tick();

    // Basic word, taken immediately: valid for exactly one cycle.
    expQ.push_back({1'b0, 16'h1234});
    applyStimulus(SSD_1);
    applyStimulus(SSD_2);
    applyStimulus(SSD_3);
    applyStimulus(SSD_4);
    @(negedge Clk);
    checkOutput("t1 valid", {31'd0, Q_Valid}, 32'h1);
    @(negedge Clk);
    checkOutput("t1 valid drop", {31'd0, Q_Valid}, 32'h0);

    // Backpressure: word held, next digit waits, then enters on the drain cycle.
    tick();
    Q_Ready = 1'b0;
    expQ.push_back({1'b0, 16'hABCD});
    expQ.push_back({1'b0, 16'h0987});
    applyStimulus(SSD_A);
    applyStimulus(SSD_B);
    applyStimulus(SSD_C);
    applyStimulus(SSD_D);
    SSD_In   = SSD_0;
    In_Valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      checkOutput("t2 stall In_Ready", {31'd0, In_Ready}, 32'h0);
      checkOutput("t2 hold Q", {16'd0, Q}, 32'hABCD);
      checkOutput("t2 hold Q_Valid", {31'd0, Q_Valid}, 32'h1);
    end
    tick();
    Q_Ready = 1'b1;
    @(negedge Clk);
    checkOutput("t2 drain In_Ready", {31'd0, In_Ready}, 32'h1);
    tick();
    In_Valid = 1'b0;
    @(negedge Clk);
    checkOutput("t2 after drain Q_Valid", {31'd0, Q_Valid}, 32'h0);
    tick();
    applyStimulus(SSD_9);
    applyStimulus(SSD_8);
    applyStimulus(SSD_7);

    // Bad code in the word, then a clean word: the error must not carry over.
    expQ.push_back({1'b1, 16'h80F0});
    expQ.push_back({1'b0, 16'h0000});
    applyStimulus(SSD_8);
    applyStimulus(7'b1111111);
    applyStimulus(SSD_F);
    applyStimulus(SSD_0);
    for (int i = 0; i < 4; i++) applyStimulus(SSD_0);
    tick();

    // Flush while holding a word drops it but leaves Q untouched.
    Q_Ready = 1'b0;
    applyStimulus(SSD_4);
    applyStimulus(SSD_3);
    applyStimulus(SSD_2);
    applyStimulus(SSD_1);
    @(negedge Clk);
    checkOutput("t4 full Q", {16'd0, Q}, 32'h4321);
    tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    @(negedge Clk);
    checkOutput("t4 flush Q_Valid", {31'd0, Q_Valid}, 32'h0);
    checkOutput("t4 flush keeps Q", {16'd0, Q}, 32'h4321);
    tick();
    Q_Ready = 1'b1;

    // Flush mid-word; a digit presented in the flush cycle is discarded too.
    applyStimulus(SSD_1);
    applyStimulus(SSD_2);
    Flush    = 1'b1;
    In_Valid = 1'b1;
    SSD_In   = SSD_9;
    tick();
    Flush    = 1'b0;
    In_Valid = 1'b0;
    expQ.push_back({1'b0, 16'h5678});
    applyStimulus(SSD_5);
    applyStimulus(SSD_6);
    applyStimulus(SSD_7);
    applyStimulus(SSD_8);
    tick();
    tick();

    // Asynchronous clear while FULL takes effect before the next edge.
    Q_Ready = 1'b0;
    applyStimulus(SSD_1);
    applyStimulus(SSD_2);
    applyStimulus(SSD_3);
    applyStimulus(SSD_4);
    @(negedge Clk);
    checkOutput("t5 full Q", {16'd0, Q}, 32'h1234);
    #2 Clr = 1'b1;
    #1;
    checkOutput("t5 clr Q", {16'd0, Q}, 32'h0);
    checkOutput("t5 clr Q_Valid", {31'd0, Q_Valid}, 32'h0);
    checkOutput("t5 clr In_Ready", {31'd0, In_Ready}, 32'h1);
    #1 Clr = 1'b0;
    tick();
    Q_Ready = 1'b1;

    // Single-digit build: back-to-back digits with no stall.
    expQ1.push_back({1'b0, 4'hE});
    expQ1.push_back({1'b0, 4'hF});
    c1InValid = 1'b1;
    c1SsdIn   = SSD_E;
    tick();
    c1SsdIn = SSD_F;
    @(negedge Clk);
    checkOutput("t6 first Q", {28'd0, c1Q}, 32'hE);
    checkOutput("t6 In_Ready", {31'd0, c1InReady}, 32'h1);
    tick();
    c1InValid = 1'b0;
    @(negedge Clk);
    checkOutput("t6 second Q", {28'd0, c1Q}, 32'hF);
    checkOutput("t6 second valid", {31'd0, c1QValid}, 32'h1);

    tick();
    tick();
    tick();
    checkOutput("queue empty", expQ.size(), 32'h0);
    checkOutput("queue1 empty", expQ1.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
